lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master_if.sv | 26 ++
 rtl/lsu_bus_master.sv | 195 +++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_bus_master_if : LSU-to-memory request/response bus bundle         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface lsu_bus_master_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_bus_master : MEM-stage load/store bus master with timeout abort   |
// | Option macro LSU_MISALIGN_TRAP_EN traps misaligned half/word access.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_bus_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        op_valid_i,
   input  wire logic        memwr_sgn_i,
   input  wire logic [2:0]  func3_i,
   input  wire logic [31:0] alu_result_i,
   input  wire logic [31:0] rd_data2_i,
   output      logic        stall_o,
   output      logic        done_o,
   output      logic [31:0] read_data_o,
   output      logic        fault_o,
   lsu_bus_master_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_e;

   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  lane_q, lane_d;
   logic        store_q, store_d;
   logic [31:0] read_data_q, read_data_d;
   logic        fault_q, fault_d;
   logic        w_tmo;

   function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] lo);
      logic [3:0] r;
      if (f3[1])      r = 4'b1111;
      else if (f3[0]) r = lo[1] ? 4'b1100 : 4'b0011;
      else            r = 4'b0001 << lo;
      return r;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      if (f3[1])      r = d;
      else if (f3[0]) r = {2{d[15:0]}};
      else            r = {4{d[7:0]}};
      return r;
   endfunction

   // Sign fill is the lane MSB unless func3[2] asks for zero extension.
   function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lo, 3'b000} +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      if (f3[1])      r = w;
      else if (f3[0]) r = {{16{h[15] & ~f3[2]}}, h};
      else            r = {{24{b[7] & ~f3[2]}}, b};
      return r;
   endfunction

   assign w_tmo = (cnt_q == c_tmo_last);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      func3_d     = func3_q;
      lane_d      = lane_q;
      store_d     = store_q;
      read_data_d = read_data_q;
      fault_d     = fault_q;

      case (state_q)
         S_IDLE: begin
            if (op_valid_i) begin
               func3_d     = func3_i;
               lane_d      = alu_result_i[1:0];
               store_d     = memwr_sgn_i;
               bus_we_d    = memwr_sgn_i;
               bus_addr_d  = {alu_result_i[31:2], 2'b00};
               bus_be_d    = f_be(func3_i, alu_result_i[1:0]);
               bus_wdata_d = memwr_sgn_i ? f_wdata(func3_i, rd_data2_i) : 32'd0;
               cnt_d       = 8'd0;
               fault_d     = 1'b0;
               read_data_d = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
               if ((func3_i[1] && (alu_result_i[1:0] != 2'b00)) ||
                   (!func3_i[1] && func3_i[0] && alu_result_i[0])) begin
                  state_d = S_RESP;
                  fault_d = 1'b1;
               end else begin
                  state_d   = S_REQ;
                  bus_req_d = 1'b1;
               end
`else
               state_d   = S_REQ;
               bus_req_d = 1'b1;
`endif
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 8'd1;
            if (w_tmo) begin
               state_d     = S_RESP;
               bus_req_d   = 1'b0;
               fault_d     = 1'b1;
               read_data_d = 32'd0;
            end else if (bus.bus_gnt) begin
               state_d   = S_WAIT;
               bus_req_d = 1'b0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A response arriving on the last allowed cycle still counts.
            if (bus.bus_rvalid) begin
               state_d     = S_RESP;
               read_data_d = store_q ? 32'd0 : f_extract(bus.bus_rdata, func3_q, lane_q);
            end else if (w_tmo) begin
               state_d     = S_RESP;
               fault_d     = 1'b1;
               read_data_d = 32'd0;
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            fault_d     = 1'b0;
            read_data_d = 32'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         func3_q     <= 3'd0;
         lane_q      <= 2'd0;
         store_q     <= 1'b0;
         read_data_q <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         func3_q     <= func3_d;
         lane_q      <= lane_d;
         store_q     <= store_d;
         read_data_q <= read_data_d;
         fault_q     <= fault_d;
      end
   end

   assign stall_o       = op_valid_i && (state_q != S_RESP);
   assign done_o        = (state_q == S_RESP);
   assign read_data_o   = read_data_q;
   assign fault_o       = fault_q;
   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_be    = bus_be_q;
   assign bus.bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_bus_master : scoreboard bench for lsu_bus_master (TIMEOUT=8)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lsu_bus_master;
   localparam int TMO = 8;

   typedef struct {
      logic [31:0] rd;
      logic        flt;
      int          lat;
      int          start;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic        memwr;
   logic [2:0]  f3;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        stall;
   logic        done;
   logic [31:0] rd;
   logic        flt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   exp_t exp_q[$];
   bus_t bus_q[$];
   exp_t mon_e;

   int          cfg_gnt_delay = 0;
   int          cfg_ack_delay = 0;
   logic [31:0] cfg_rdata = 32'd0;

   lsu_bus_master_if bus_if();

   lsu_bus_master #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .op_valid_i   (op_valid),
      .memwr_sgn_i  (memwr),
      .func3_i      (f3),
      .alu_result_i (addr),
      .rd_data2_i   (wd),
      .stall_o      (stall),
      .done_o       (done),
      .read_data_o  (rd),
      .fault_o      (flt),
      .bus          (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory responder: grants after cfg_gnt_delay cycles of req, acks cfg_ack_delay later.
   initial begin
      int wait_cnt;
      int ack_cnt;
      wait_cnt = 0;
      ack_cnt  = -1;
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         bus_if.bus_gnt    = 1'b0;
         bus_if.bus_rvalid = 1'b0;
         bus_if.bus_rdata  = 32'd0;
         if (ack_cnt == 0) begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = cfg_rdata;
            ack_cnt = -1;
         end else if (ack_cnt > 0) begin
            ack_cnt--;
         end
         if (rst || !bus_if.bus_req) begin
            wait_cnt = 0;
         end else if (bus_q.size() == 0) begin
            chk("bus_req_unexpected", 32'(bus_if.bus_req), 32'd0);
         end else begin
            chk("bus_we", 32'(bus_if.bus_we), 32'(bus_q[0].we));
            chk("bus_addr", bus_if.bus_addr, bus_q[0].addr);
            chk("bus_be", 32'(bus_if.bus_be), 32'(bus_q[0].be));
            chk("bus_wdata", bus_if.bus_wdata, bus_q[0].wdata);
            if (wait_cnt == cfg_gnt_delay) begin
               bus_if.bus_gnt = 1'b1;
               ack_cnt  = cfg_ack_delay;
               wait_cnt = 0;
               void'(bus_q.pop_front());
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Completion monitor
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("read_data", rd, mon_e.rd);
            chk("fault", 32'(flt), 32'(mon_e.flt));
            chk("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input logic bus_exp, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic eflt,
                        input int elat);
      exp_t e;
      bus_t b;
      bit   seen;
      @(negedge clk);
      memwr = st; f3 = fn; addr = a; wd = d; op_valid = 1'b1;
      e.rd = erd; e.flt = eflt; e.lat = elat; e.start = cyc;
      exp_q.push_back(e);
      if (bus_exp) begin
         b.we = st; b.addr = {a[31:2], 2'b00}; b.be = ebe; b.wdata = ewd;
         bus_q.push_back(b);
      end
      #1 chk("stall_issue", 32'(stall), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 32'(done), 32'd1);
      else       chk("stall_at_done", 32'(stall), 32'd0);
      op_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bus_req"}, 32'(bus_if.bus_req), 32'd0);
      chk({tag, "_bus_we"}, 32'(bus_if.bus_we), 32'd0);
      chk({tag, "_bus_addr"}, bus_if.bus_addr, 32'd0);
      chk({tag, "_bus_be"}, 32'(bus_if.bus_be), 32'd0);
      chk({tag, "_bus_wdata"}, bus_if.bus_wdata, 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_fault"}, 32'(flt), 32'd0);
      chk({tag, "_read_data"}, rd, 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; op_valid = 1'b0; memwr = 1'b0; f3 = 3'd0; addr = 32'd0; wd = 32'd0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      cfg_gnt_delay = 0; cfg_ack_delay = 0;
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 3);

      cfg_rdata = 32'h80FF0000;
      issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 3);
      issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 4'b1000, 32'h0, 32'h00000080, 1'b0, 3);

      cfg_gnt_delay = 4;
      issue(1'b1, 3'b001, 32'h22, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 32'h0, 1'b0, 7);
      cfg_gnt_delay = 0;

      issue(1'b1, 3'b000, 32'h05, 32'h000000A7, 1'b1, 4'b0010, 32'hA7A7A7A7, 32'h0, 1'b0, 3);

      cfg_rdata = 32'h80011234;
      issue(1'b0, 3'b001, 32'h02, 32'h0, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 3);
      issue(1'b0, 3'b101, 32'h02, 32'h0, 1'b1, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3);

      // Granted but acked long after the timeout; the late ack must be dropped.
      cfg_ack_delay = 12; cfg_rdata = 32'hCAFEF00D;
      issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 9);
      repeat (16) @(negedge clk);
      cfg_ack_delay = 0;

      cfg_gnt_delay = 100;
      issue(1'b0, 3'b010, 32'h34, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 9);
      bus_q.delete();
      cfg_gnt_delay = 0;

      cfg_rdata = 32'h0000F00D;
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 3'b001, 32'h01, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
`else
      issue(1'b0, 3'b001, 32'h01, 32'h0, 1'b1, 4'b0011, 32'h0, 32'hFFFFF00D, 1'b0, 3);
`endif

      // Asynchronous reset while waiting for the response.
      cfg_ack_delay = 6; cfg_rdata = 32'h11111111;
      @(negedge clk);
      memwr = 1'b1; f3 = 3'b010; addr = 32'h40; wd = 32'h55AA55AA; op_valid = 1'b1;
      bus_q.push_back('{we: 1'b1, addr: 32'h40, be: 4'b1111, wdata: 32'h55AA55AA});
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_all_zero("async_rst");
      op_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      cfg_ack_delay = 0;

      cfg_rdata = 32'h12345678;
      issue(1'b0, 3'b100, 32'h41, 32'h0, 1'b1, 4'b0010, 32'h0, 32'h00000056, 1'b0, 3);

      repeat (3) @(negedge clk);
      chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
